im_loader: RTL and testbench
============================

IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first instruction word written.
REQ-002 Parameter MAX_WORDS, default 1024, instruction memory depth in 32-bit words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  load request, sampled in IDLE only.
REQ-006 word_count  input  11  number of words to load, sampled with start.
REQ-007 byte_valid  input  1  source presents a byte.
REQ-008 byte_data  input  8  program byte.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 im_we  output  1  instruction memory write strobe.
REQ-011 im_addr  output  32  byte address of word being written; memory indexes with bits [11:2].
REQ-012 im_wdata  output  32  assembled instruction word.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 cpu_hold  output  1  equals busy; holds pc/fetch while the memory is rewritten.
REQ-015 done  output  1  one-cycle pulse when the last word has been written.
REQ-016 err  output  1  one-cycle pulse on a rejected start.

Function
REQ-017 FSM states SHALL be IDLE, RECV, WRITE, DONE.
REQ-018 IDLE: start=1 with 1 <= word_count <= MAX_WORDS -> RECV; load addr=BASE_ADDR, byte counter=0, words_left=word_count.
REQ-019 IDLE: start=1 with word_count=0 or > MAX_WORDS -> err pulse next cycle, remain IDLE, no write.
REQ-020 start SHALL be ignored in RECV, WRITE, DONE.
REQ-021 byte_ready SHALL be 1 only in RECV; a byte is accepted only when byte_valid & byte_ready on a rising edge.
REQ-022 Byte assembly big-endian: 1st accepted byte -> [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
REQ-023 byte_valid gaps in RECV SHALL stall without losing assembled bytes; counter advances only on handshake.
REQ-024 The 4th accepted byte SHALL move RECV -> WRITE; im_we=1 for exactly the WRITE cycle (one cycle after 4th handshake), with im_addr and im_wdata stable in that cycle.
REQ-025 After WRITE: im_addr += 4 (32-bit wrap), words_left -= 1, byte counter=0; words_left=0 -> DONE, else -> RECV.
REQ-026 DONE: done=1 for one cycle, then IDLE; busy still 1 in DONE.
REQ-027 im_we SHALL never be asserted outside WRITE; total writes per load equal word_count exactly.
REQ-028 im_addr and im_wdata SHALL hold their last values outside WRITE.
REQ-029 Minimum load time: 5*word_count + 2 cycles from start to return to IDLE (start cycle, 4 bytes + 1 write per word, DONE).

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, byte_ready=0, im_we=0, busy=0, cpu_hold=0, done=0, err=0, im_addr=BASE_ADDR, im_wdata=0, counters=0.
REQ-031 Reset mid-load SHALL abort without completing the partial word; words already written remain in memory; no done pulse.
REQ-032 Deassertion of rst_n needs no start; loader waits in IDLE.

Verification
REQ-033 word_count=1, bytes 8C,01,00,04 back-to-back -> single write, im_addr=0, im_wdata=32'h8C01_0004, done pulse 7 cycles after start.
REQ-034 word_count=3, byte_valid toggling every other cycle -> three writes at 0x0, 0x4, 0x8, correct words, no extra im_we, busy high throughout.
REQ-035 word_count=0 and word_count=1025 -> err pulse each, no im_we, busy stays 0.
REQ-036 Assert start again mid-load with word_count=5 -> ignored; original count completes.
REQ-037 rst_n low after 2 bytes of word 2 -> outputs at reset values same cycle; next load restarts at BASE_ADDR; byte ordering unaffected.
REQ-038 word_count=1024 full load -> last write at im_addr=0xFFC, done pulse, im_addr then 0x1000.

Source files
------------

// File: rtl/im_loader.sv
// Instruction memory loader: assembles a big-endian byte stream into
// 32-bit words and writes them from BASE_ADDR while holding the CPU.
module im_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [31:0] MaxW = MAX_WORDS;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [10:0] left_q, left_d;
  logic        err_q, err_d;
  logic        cnt_ok;
  logic [31:0] asm_nx;

  assign cnt_ok = (word_count != 11'd0) &&
                  ({21'd0, word_count} <= MaxW);
  assign asm_nx = {asm_q[23:0], byte_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= BASE_ADDR;
      asm_q   <= '0;
      wdata_q <= '0;
      bcnt_q  <= '0;
      left_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      asm_q   <= asm_d;
      wdata_q <= wdata_d;
      bcnt_q  <= bcnt_d;
      left_q  <= left_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    asm_d   = asm_q;
    wdata_d = wdata_q;
    bcnt_d  = bcnt_q;
    left_d  = left_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && cnt_ok) begin
          state_d = RECV;
          addr_d  = BASE_ADDR;
          bcnt_d  = 2'd0;
          left_d  = word_count;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      RECV: begin
        if (byte_valid) begin
          asm_d  = asm_nx;
          bcnt_d = bcnt_q + 2'd1;
          // Output word only moves on the 4th byte so it stays put otherwise
          if (bcnt_q == 2'd3) begin
            wdata_d = asm_nx;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        addr_d  = addr_q + 32'd4;
        left_d  = left_q - 11'd1;
        bcnt_d  = 2'd0;
        state_d = (left_q == 11'd1) ? DONE : RECV;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign byte_ready = (state_q == RECV);
  assign im_we      = (state_q == WRITE);
  assign im_addr    = addr_q;
  assign im_wdata   = wdata_q;
  assign busy       = (state_q != IDLE);
  assign cpu_hold   = busy;
  assign done       = (state_q == DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected writes are queued as bytes
// are driven and popped when the loader strobes im_we.
module tb_im_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] word_count = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, im_we, busy, cpu_hold, done, err;
  logic [31:0] im_addr, im_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit in_load = 1'b0;
  logic [63:0] sb[$];

  im_loader #(.BASE_ADDR(BASE), .MAX_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .word_count(word_count), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (im_we) begin
        we_cnt = we_cnt + 1;
        if (sb.size() == 0) begin
          chk("we_spurious", 64'(im_we), 64'd0);
        end else begin
          logic [63:0] e;
          e = sb.pop_front();
          chk("we_addr", 64'(im_addr), 64'(e[63:32]));
          chk("we_data", 64'(im_wdata), 64'(e[31:0]));
        end
      end
      if (done) done_cnt = done_cnt + 1;
      if (err) err_cnt = err_cnt + 1;
      if (in_load) begin
        chk("busy_hold", 64'(busy), 64'd1);
        chk("cpu_hold", 64'(cpu_hold), 64'd1);
      end
    end
  end

  task automatic rst_chk(input string pfx);
    chk({pfx, "_ready"}, 64'(byte_ready), 64'd0);
    chk({pfx, "_we"}, 64'(im_we), 64'd0);
    chk({pfx, "_busy"}, 64'(busy), 64'd0);
    chk({pfx, "_hold"}, 64'(cpu_hold), 64'd0);
    chk({pfx, "_done"}, 64'(done), 64'd0);
    chk({pfx, "_err"}, 64'(err), 64'd0);
    chk({pfx, "_addr"}, 64'(im_addr), 64'(BASE));
    chk({pfx, "_wdata"}, 64'(im_wdata), 64'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit rdy;
    int guard;
    if (gap) begin
      byte_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    guard = 0;
    forever begin
      @(negedge clk);
      rdy = byte_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      guard = guard + 1;
      if (guard > 50) begin
        chk("byte_timeout", 64'(byte_ready), 64'd1);
        break;
      end
    end
  endtask

  task automatic wait_done(output int dc);
    int guard;
    guard = 0;
    dc = -1;
    while (guard < 12) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        break;
      end
      guard = guard + 1;
    end
    if (dc < 0) chk("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic load(input int n, input bit gap, input bit poke,
                      input bit fixed);
    logic [31:0] w;
    int c0, dc;
    start = 1'b1;
    word_count = n[10:0];
    @(posedge clk);
    #1;
    c0 = cyc;
    start = 1'b0;
    in_load = 1'b1;
    for (int i = 0; i < n; i++) begin
      w = fixed ? 32'h8C01_0004 : $urandom;
      sb.push_back({BASE + 32'(4 * i), w});
      start = poke && (i == 0);
      if (poke) word_count = 11'd5;
      for (int k = 0; k < 4; k++) begin
        send_byte(w[31 - 8 * k -: 8], gap);
      end
    end
    byte_valid = 1'b0;
    start = 1'b0;
    wait_done(dc);
    in_load = 1'b0;
    if (!gap) chk("load_cycles", 64'(dc - c0 + 2), 64'(5 * n + 2));
    chk("addr_after", 64'(im_addr), 64'(BASE + 32'(4 * n)));
    chk("sb_empty", 64'(sb.size()), 64'd0);
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic bad_start(input logic [10:0] wc);
    start = 1'b1;
    word_count = wc;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("err_pulse", 64'(err), 64'd1);
    chk("err_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("err_clear", 64'(err), 64'd0);
    chk("err_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    logic [31:0] w;
    #12;
    rst_chk("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_busy", 64'(busy), 64'd0);

    load(1, 1'b0, 1'b0, 1'b1);
    load(3, 1'b1, 1'b0, 1'b0);
    bad_start(11'd0);
    bad_start(11'd1025);
    load(2, 1'b0, 1'b1, 1'b0);

    // Abort: one full word, then two bytes of the second
    dn = done_cnt;
    start = 1'b1;
    word_count = 11'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    w = $urandom;
    sb.push_back({BASE, w});
    for (int k = 0; k < 4; k++) send_byte(w[31 - 8 * k -: 8], 1'b0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_chk("abort");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_nodone", 64'(done_cnt), 64'(dn));
    chk("abort_sb", 64'(sb.size()), 64'd0);
    load(2, 1'b0, 1'b0, 1'b0);

    load(1024, 1'b0, 1'b0, 1'b0);

    chk("we_total", 64'(we_cnt), 64'd1033);
    chk("done_total", 64'(done_cnt), 64'd5);
    chk("err_total", 64'(err_cnt), 64'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
